// File: rtl/nes_bus_arbiter.sv
// Sequences the 6502 core (reset/pause/run/step) and shares the single-port memory with host commands.
// Optional single-step support is compiled in with NES_STEP_EN.
module nes_bus_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int RESET_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              cpu_reset,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_dout,
  input  logic              cpu_write,
  input  logic              cpu_sync,
  output logic [DATA_W-1:0] cpu_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out,
  output logic              running
);

  localparam int CNT_W = $clog2(RESET_CYCLES);
  localparam logic [7:0] OP_RESET = 8'd0;
  localparam logic [7:0] OP_START = 8'd1;
  localparam logic [7:0] OP_PAUSE = 8'd2;
  localparam logic [7:0] OP_WRITE = 8'd3;
  localparam logic [7:0] OP_READ  = 8'd4;

`ifdef NES_STEP_EN
  localparam logic [7:0] OP_STEP  = 8'd5;
  typedef enum logic [2:0] {ST_RST, ST_PAUSED, ST_RUN, ST_H_WR, ST_H_RD, ST_H_RD2, ST_STEP} state_t;
  logic step_first, step_first_d;
`else
  typedef enum logic [2:0] {ST_RST, ST_PAUSED, ST_RUN, ST_H_WR, ST_H_RD, ST_H_RD2} state_t;
  logic unused_sync;
  assign unused_sync = cpu_sync;
`endif

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ret_run, ret_run_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic              accept;

  assign cpu_din = mem_out;
  assign running = (state == ST_RUN);

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ret_run_d   = ret_run;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data;
    cpu_reset   = 1'b0;
    cpu_ready   = 1'b0;
    cmd_ready   = 1'b0;
    mem_addr    = cpu_addr;
    mem_in      = cpu_dout;
    mem_write   = 1'b0;
`ifdef NES_STEP_EN
    step_first_d = 1'b0;
`endif
    case (state)
      ST_RST: begin
        cpu_reset = 1'b1;
        if (cnt == '0) state_d = ST_PAUSED;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      ST_PAUSED: cmd_ready = 1'b1;
      ST_RUN: begin
        cmd_ready = 1'b1;
        cpu_ready = 1'b1;
        mem_write = cpu_write;
      end
      ST_H_WR: begin
        mem_addr  = addr_q;
        mem_in    = wdata_q;
        mem_write = 1'b1;
        state_d   = ret_run ? ST_RUN : ST_PAUSED;
      end
      ST_H_RD: begin
        mem_addr = addr_q;
        state_d  = ST_H_RD2;
      end
      ST_H_RD2: begin
        mem_addr    = addr_q;
        rsp_valid_d = 1'b1;
        rsp_data_d  = mem_out;
        state_d     = ret_run ? ST_RUN : ST_PAUSED;
      end
`ifdef NES_STEP_EN
      ST_STEP: begin
        // The sync on the very first cycle is the fetch the core was parked on.
        if (cpu_sync && !step_first) begin
          state_d     = ST_PAUSED;
          rsp_valid_d = 1'b1;
          rsp_data_d  = DATA_W'(cpu_addr[7:0]);
        end else begin
          cpu_ready = 1'b1;
        end
      end
`endif
      default: state_d = ST_RST;
    endcase

    // A reset command may interrupt anything, including an in-flight host access.
    if (cmd_valid && cmd_op == OP_RESET) cmd_ready = 1'b1;
    accept = cmd_valid && cmd_ready;

    if (accept) begin
      case (cmd_op)
        OP_RESET: begin
          state_d     = ST_RST;
          cnt_d       = CNT_W'(RESET_CYCLES - 1);
          rsp_valid_d = 1'b0;
        end
        OP_START: state_d = ST_RUN;
        OP_PAUSE: state_d = ST_PAUSED;
        OP_WRITE, OP_READ: begin
          state_d   = (cmd_op == OP_WRITE) ? ST_H_WR : ST_H_RD;
          addr_d    = cmd_addr;
          wdata_d   = cmd_data;
          ret_run_d = (state == ST_RUN);
          cpu_ready = 1'b0;
          mem_write = 1'b0;
        end
`ifdef NES_STEP_EN
        OP_STEP: begin
          if (state == ST_RUN) begin
            state_d = ST_PAUSED;
          end else begin
            state_d      = ST_STEP;
            step_first_d = 1'b1;
          end
        end
`endif
        default: begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = DATA_W'(8'hEE);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RST;
      cnt       <= CNT_W'(RESET_CYCLES - 1);
      addr_q    <= '0;
      wdata_q   <= '0;
      ret_run   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
`ifdef NES_STEP_EN
      step_first <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ret_run   <= ret_run_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
`ifdef NES_STEP_EN
      step_first <= step_first_d;
`endif
    end
  end

endmodule

// File: tb/tb_nes_bus_arbiter.sv
// Directed bench for nes_bus_arbiter: per-cycle vector table plus hand sequences for reset and step.
module tb_nes_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        cpu_reset, cpu_ready;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_write, cpu_sync;
  logic [7:0]  cpu_din;
  logic [15:0] mem_addr;
  logic        mem_write;
  logic [7:0]  mem_in;
  logic [7:0]  mem_out;
  logic        running;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nes_bus_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .cpu_reset(cpu_reset), .cpu_ready(cpu_ready),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_write(cpu_write), .cpu_sync(cpu_sync),
    .cpu_din(cpu_din),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_in(mem_in), .mem_out(mem_out),
    .running(running)
  );

  // Single-port synchronous RAM, read-before-write, one cycle read latency.
  logic [7:0] mem [65536] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_in;
    mem_out <= mem[mem_addr];
  end

  typedef struct {
    logic        v;
    logic [7:0]  op;
    logic [15:0] a;
    logic [7:0]  d;
    logic        cw;
    logic [15:0] ca;
    logic [7:0]  cd;
    logic [5:0]  ex;  // {cmd_ready, cpu_ready, cpu_reset, mem_write, running, rsp_valid}
    logic [7:0]  rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t cmd(input logic [7:0] op, input logic [15:0] a, input logic [7:0] d,
                               input logic cw, input logic [15:0] ca, input logic [7:0] cd,
                               input logic [5:0] ex, input logic [7:0] rd);
    vec_t r;
    r.v = 1'b1; r.op = op; r.a = a; r.d = d;
    r.cw = cw; r.ca = ca; r.cd = cd; r.ex = ex; r.rd = rd;
    return r;
  endfunction

  function automatic vec_t idl(input logic cw, input logic [15:0] ca, input logic [7:0] cd,
                               input logic [5:0] ex, input logic [7:0] rd);
    vec_t r;
    r = cmd(8'd0, 16'h0, 8'h0, cw, ca, cd, ex, rd);
    r.v = 1'b0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, req);
    end
  endtask

  function automatic logic [5:0] flags();
    return {cmd_ready, cpu_ready, cpu_reset, mem_write, running, rsp_valid};
  endfunction

  task automatic drive(input logic v, input logic [7:0] op, input logic [15:0] a, input logic [7:0] d,
                       input logic cw, input logic [15:0] ca, input logic [7:0] cd, input logic sy);
    cmd_valid = v; cmd_op = op; cmd_addr = a; cmd_data = d;
    cpu_write = cw; cpu_addr = ca; cpu_dout = cd; cpu_sync = sy;
  endtask

  initial begin
    int hi;
    reset_n = 1'b0;
    drive(1'b0, 8'h0, 16'h0, 8'h0, 1'b0, 16'h0, 8'h0, 1'b0);

    // Vector table: one row per cycle, starting from PAUSED.
    tbl.push_back(cmd(8'd3, 16'h8000, 8'hA9, 1'b0, 16'h0, 8'h0, 6'b100000, 8'h00));
    tbl.push_back(idl(1'b0, 16'h0, 8'h0, 6'b000100, 8'h00));
    tbl.push_back(cmd(8'd4, 16'h8000, 8'h00, 1'b0, 16'h0, 8'h0, 6'b100000, 8'h00));
    tbl.push_back(idl(1'b0, 16'h0, 8'h0, 6'b000000, 8'h00));
    tbl.push_back(idl(1'b0, 16'h0, 8'h0, 6'b000000, 8'h00));
    tbl.push_back(idl(1'b0, 16'h0, 8'h0, 6'b100001, 8'hA9));
    tbl.push_back(cmd(8'd1, 16'h0, 8'h0, 1'b0, 16'h0, 8'h0, 6'b100000, 8'h00));
    tbl.push_back(idl(1'b1, 16'h0200, 8'h55, 6'b110110, 8'h00));
    tbl.push_back(cmd(8'd4, 16'h0200, 8'h00, 1'b1, 16'h0200, 8'h55, 6'b100010, 8'h00));
    tbl.push_back(idl(1'b1, 16'h0200, 8'h55, 6'b000000, 8'h00));
    tbl.push_back(idl(1'b1, 16'h0200, 8'h55, 6'b000000, 8'h00));
    tbl.push_back(idl(1'b1, 16'h0200, 8'h55, 6'b110111, 8'h55));
    tbl.push_back(cmd(8'd7, 16'h0, 8'h0, 1'b0, 16'h0, 8'h0, 6'b110010, 8'h00));
    tbl.push_back(idl(1'b0, 16'h0, 8'h0, 6'b110011, 8'hEE));
    tbl.push_back(cmd(8'd4, 16'h8000, 8'h00, 1'b0, 16'h0, 8'h0, 6'b100010, 8'h00));
    tbl.push_back(cmd(8'd0, 16'h0, 8'h0, 1'b0, 16'h0, 8'h0, 6'b100000, 8'h00));
    for (int k = 0; k < 8; k++) tbl.push_back(idl(1'b0, 16'h0, 8'h0, 6'b001000, 8'h00));
    tbl.push_back(idl(1'b0, 16'h0, 8'h0, 6'b100000, 8'h00));
    tbl.push_back(cmd(8'd1, 16'h0, 8'h0, 1'b0, 16'h0, 8'h0, 6'b100000, 8'h00));
    tbl.push_back(cmd(8'd1, 16'h0, 8'h0, 1'b0, 16'h0, 8'h0, 6'b110010, 8'h00));
    tbl.push_back(cmd(8'd3, 16'h0300, 8'h77, 1'b1, 16'h0200, 8'h66, 6'b100010, 8'h00));
    tbl.push_back(idl(1'b1, 16'h0200, 8'h66, 6'b000100, 8'h00));
    tbl.push_back(idl(1'b1, 16'h0200, 8'h66, 6'b110110, 8'h00));
    tbl.push_back(cmd(8'd2, 16'h0, 8'h0, 1'b1, 16'h0200, 8'h66, 6'b110110, 8'h00));
    tbl.push_back(idl(1'b1, 16'h0200, 8'h66, 6'b100000, 8'h00));
    tbl.push_back(cmd(8'd2, 16'h0, 8'h0, 1'b0, 16'h0, 8'h0, 6'b100000, 8'h00));
    tbl.push_back(cmd(8'd4, 16'h0300, 8'h00, 1'b0, 16'h0, 8'h0, 6'b100000, 8'h00));
    tbl.push_back(idl(1'b0, 16'h0, 8'h0, 6'b000000, 8'h00));
    tbl.push_back(idl(1'b0, 16'h0, 8'h0, 6'b000000, 8'h00));
    tbl.push_back(idl(1'b0, 16'h0, 8'h0, 6'b100001, 8'h77));
    tbl.push_back(cmd(8'd4, 16'h0200, 8'h00, 1'b0, 16'h0, 8'h0, 6'b100000, 8'h00));
    tbl.push_back(idl(1'b0, 16'h0, 8'h0, 6'b000000, 8'h00));
    tbl.push_back(idl(1'b0, 16'h0, 8'h0, 6'b000000, 8'h00));
    tbl.push_back(idl(1'b0, 16'h0, 8'h0, 6'b100001, 8'h66));

    // Reset state, then cpu_reset must stay high for exactly RESET_CYCLES cycles.
    #3;
    chk("reset flags", 16'(flags()), 16'(6'b001000));
    chk("reset rsp_data", 16'(rsp_data), 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    hi = 0;
    for (int k = 0; k < 20 && cpu_reset; k++) begin
      hi++;
      @(negedge clk);
      #1;
    end
    chk("cpu_reset cycles", 16'(hi), 16'd8);
    chk("paused after reset", 16'(flags()), 16'(6'b100000));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].op, tbl[i].a, tbl[i].d, tbl[i].cw, tbl[i].ca, tbl[i].cd, 1'b0);
      #1;
      chk($sformatf("row%0d flags", i), 16'(flags()), 16'(tbl[i].ex));
      if (tbl[i].ex[0]) chk($sformatf("row%0d rsp_data", i), 16'(rsp_data), 16'(tbl[i].rd));
    end

    // Single step from PAUSED over a 2-byte opcode at 16'h8000.
    @(negedge clk);
    drive(1'b1, 8'd5, 16'h0, 8'h0, 1'b0, 16'h8000, 8'h0, 1'b1);
    #1;
    chk("step accept", 16'({cmd_ready, cpu_ready}), 16'(2'b10));
`ifdef NES_STEP_EN
    @(negedge clk);
    drive(1'b0, 8'd0, 16'h0, 8'h0, 1'b0, 16'h8000, 8'h0, 1'b1);
    #1;
    chk("step first sync", 16'(cpu_ready), 16'd1);
    @(negedge clk);
    drive(1'b0, 8'd0, 16'h0, 8'h0, 1'b0, 16'h8001, 8'h0, 1'b0);
    #1;
    chk("step operand", 16'(cpu_ready), 16'd1);
    @(negedge clk);
    drive(1'b0, 8'd0, 16'h0, 8'h0, 1'b0, 16'h8002, 8'h0, 1'b1);
    #1;
    chk("step next sync", 16'(cpu_ready), 16'd0);
`endif
    @(negedge clk);
    drive(1'b0, 8'd0, 16'h0, 8'h0, 1'b0, 16'h8002, 8'h0, 1'b0);
    #1;
    chk("step done flags", 16'(flags()), 16'(6'b100001));
`ifdef NES_STEP_EN
    chk("step rsp_data", 16'(rsp_data), 16'h02);
`else
    chk("step rsp_data", 16'(rsp_data), 16'hEE);
`endif

    // Async reset while a host write is on the bus: outputs clear at once and the write is lost.
    @(negedge clk);
    drive(1'b1, 8'd3, 16'h0400, 8'h5A, 1'b0, 16'h0, 8'h0, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'd0, 16'h0, 8'h0, 1'b0, 16'h0, 8'h0, 1'b0);
    #1;
    chk("h_wr mem_write", 16'(mem_write), 16'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async reset flags", 16'(flags()), 16'(6'b001000));
    chk("async reset rsp_data", 16'(rsp_data), 16'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    drive(1'b1, 8'd4, 16'h0400, 8'h0, 1'b0, 16'h0, 8'h0, 1'b0);
    #1;
    chk("re-paused cmd_ready", 16'(cmd_ready), 16'd1);
    @(negedge clk);
    drive(1'b0, 8'd0, 16'h0, 8'h0, 1'b0, 16'h0, 8'h0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("dropped write rsp_valid", 16'(rsp_valid), 16'd1);
    chk("dropped write data", 16'(rsp_data), 16'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
